// File: rtl/lsu_mem_if.sv
// Load/store unit: turns a core load/store into one req/ack word access on the
// data bus, stalling the core until it completes, faults, or times out.
module lsu_mem_if #(
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned TMO_W       = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] w_data,
  output logic [31:0] r_data,
  output logic        stall,
  output logic        done,
  output logic        access_err,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

  state_e           state_q, state_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic [31:0]      r_data_q, r_data_d;
  logic [31:0]      bus_addr_q, bus_addr_d;
  logic [31:0]      bus_wdata_q, bus_wdata_d;
  logic [3:0]       bus_wstrb_q, bus_wstrb_d;
  logic             bus_we_q, bus_we_d;
  logic [2:0]       f3_q, f3_d;
  logic [1:0]       off_q, off_d;
  logic             aerr_q, aerr_d;
  logic             berr_q, berr_d;

  logic             req_any;
  logic             f3_ok;
  logic             aligned;
  logic             timeout_hit;
  logic [31:0]      wdata_lane;
  logic [3:0]       wstrb_lane;

  function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                               input logic [1:0]  off,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return word;
    endcase
  endfunction

  assign req_any = mem_read | mem_write;
  // Stores only know B/H/W; loads additionally accept the unsigned variants.
  assign f3_ok   = mem_write ? (funct3 inside {3'b000, 3'b001, 3'b010})
                             : (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  assign aligned = (funct3[1:0] == 2'b00) ||
                   (funct3[1:0] == 2'b01 && !addr[0]) ||
                   (addr[1:0] == 2'b00);
  assign timeout_hit = (ACK_TIMEOUT != 0) && (cnt_q == TMO_W'(ACK_TIMEOUT - 1));

  always_comb begin
    case (funct3[1:0])
      2'b00: begin
        wdata_lane = {4{w_data[7:0]}};
        wstrb_lane = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        wdata_lane = {2{w_data[15:0]}};
        wstrb_lane = addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata_lane = w_data;
        wstrb_lane = 4'b1111;
      end
    endcase
  end

  always_comb begin
    // NOTE: every *_d gets a default first so no path leaves one unassigned (no latches).
    state_d     = state_q;
    cnt_d       = cnt_q;
    r_data_d    = r_data_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_wstrb_d = bus_wstrb_q;
    bus_we_d    = bus_we_q;
    f3_d        = f3_q;
    off_d       = off_q;
    aerr_d      = 1'b0;
    berr_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_any) begin
          if (!f3_ok || !aligned) begin
            aerr_d  = 1'b1;
            state_d = DONE;
          end else begin
            bus_addr_d  = {addr[31:2], 2'b00};
            bus_we_d    = mem_write;
            bus_wdata_d = wdata_lane;
            bus_wstrb_d = mem_write ? wstrb_lane : 4'b0000;
            f3_d        = funct3;
            off_d       = addr[1:0];
            cnt_d       = '0;
            state_d     = REQ;
          end
        end
      end
      REQ: begin
        if (bus_ack || timeout_hit) begin
          if (!bus_we_q) r_data_d = bus_ack ? load_extract(f3_q, off_q, bus_rdata) : 32'h0;
          berr_d      = !bus_ack;
          bus_we_d    = 1'b0;
          bus_wstrb_d = 4'b0000;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + TMO_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      r_data_q    <= 32'h0;
      bus_addr_q  <= 32'h0;
      bus_wdata_q <= 32'h0;
      bus_wstrb_q <= 4'b0000;
      bus_we_q    <= 1'b0;
      f3_q        <= 3'b000;
      off_q       <= 2'b00;
      aerr_q      <= 1'b0;
      berr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      r_data_q    <= r_data_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wstrb_q <= bus_wstrb_d;
      bus_we_q    <= bus_we_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      aerr_q      <= aerr_d;
      berr_q      <= berr_d;
    end
  end

  // bus_req and stall decode straight from state so an async reset drops them at once.
  assign bus_req    = (state_q == REQ);
  assign stall      = ((state_q == IDLE) && req_any) || (state_q == REQ);
  assign done       = (state_q == DONE);
  assign access_err = aerr_q;
  assign bus_err    = berr_q;
  assign r_data     = r_data_q;
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;
  assign bus_wstrb  = bus_wstrb_q;

endmodule

// File: tb/tb_lsu_mem_if.sv
// Self-checking bench for lsu_mem_if: directed cases from the access rules plus
// randomized transactions, compared every cycle against a transaction-level model.
module tb_lsu_mem_if;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0, w_data = 32'h0;
  logic [31:0] r_data;
  logic        stall, done, access_err, bus_err, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'h0;

  lsu_mem_if #(.ACK_TIMEOUT(TMO), .TMO_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .w_data(w_data), .r_data(r_data),
    .stall(stall), .done(done), .access_err(access_err), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected outputs for the current cycle, set by the driver, checked at negedge.
  bit          chk_en = 0;
  logic        e_stall = 0, e_req = 0, e_done = 0, e_aerr = 0, e_berr = 0, e_we = 0;
  logic [31:0] e_addr = 0, e_wdata = 0;
  logic [3:0]  e_wstrb = 0;
  logic [31:0] m_rdata = 0;
  int          n_stall = 0, n_done = 0, n_req = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", stall, e_stall);
      check("bus_req", bus_req, e_req);
      check("done", done, e_done);
      check("access_err", access_err, e_aerr);
      check("bus_err", bus_err, e_berr);
      check("r_data", r_data, m_rdata);
      if (e_req) begin
        check("bus_we", bus_we, e_we);
        check("bus_addr", bus_addr, e_addr);
        check("bus_wstrb", bus_wstrb, e_wstrb);
        if (e_we) check("bus_wdata", bus_wdata, e_wdata);
      end
      if (stall) n_stall++;
      if (done) n_done++;
      if (bus_req) n_req++;
    end
  end

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] w);
    logic [31:0] s;
    s = w >> (8 * (a % 4));
    case (f3[1:0])
      2'd0: begin s &= 32'hFF;   if (!f3[2] && s[7])  s |= 32'hFFFF_FF00; end
      2'd1: begin s &= 32'hFFFF; if (!f3[2] && s[15]) s |= 32'hFFFF_0000; end
      default: s = w;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] m_wrep(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'd0:    return (wd & 32'hFF) * 32'h0101_0101;
      2'd1:    return (wd & 32'hFFFF) * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] t;
    int nb;
    nb = 1 << f3[1:0];
    t = ((32'h1 << nb) - 1) << (a % 4);
    return t[3:0];
  endfunction

  task automatic set_exp(input logic st, input logic rq, input logic dn,
                         input logic ae, input logic be);
    e_stall = st; e_req = rq; e_done = dn; e_aerr = ae; e_berr = be;
  endtask

  // One complete core access; ack_k = REQ cycle index that sees bus_ack (>= TMO: never).
  task automatic access(input bit wr, input bit rd, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int ack_k, input logic [31:0] rword);
    bit legal, err, timed_out;
    int nb;
    legal = wr ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    nb    = 1 << f3[1:0];
    err   = !legal || ((a % nb) != 0);

    mem_write = wr; mem_read = rd; funct3 = f3; addr = a; w_data = wd;
    set_exp(1, 0, 0, 0, 0);
    @(posedge clk); #1;
    if (err) begin
      mem_read = 0; mem_write = 0;
      set_exp(0, 0, 1, 1, 0);
      @(posedge clk); #1;
      set_exp(0, 0, 0, 0, 0);
      return;
    end
    timed_out = 1;
    e_we = wr; e_addr = a & ~32'h3; e_wdata = m_wrep(f3, wd);
    e_wstrb = wr ? m_strb(f3, a) : 4'b0000;
    for (int k = 0; k < TMO; k++) begin
      set_exp(1, 1, 0, 0, 0);
      bus_ack   = (k == ack_k);
      bus_rdata = (k == ack_k) ? rword : $urandom;
      @(posedge clk); #1;
      bus_ack = 0;
      if (k == ack_k) begin
        timed_out = 0;
        break;
      end
    end
    if (!wr) m_rdata = timed_out ? 32'h0 : m_load(f3, a, rword);
    mem_read = 0; mem_write = 0;
    set_exp(0, 0, 1, 0, timed_out);
    @(posedge clk); #1;
    set_exp(0, 0, 0, 0, 0);
  endtask

  initial begin
    #1;
    check("rst_bus_req", bus_req, 1'b0);
    check("rst_stall", stall, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_r_data", r_data, 32'h0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_bus_wdata", bus_wdata, 32'h0);
    check("rst_bus_wstrb", bus_wstrb, 4'h0);
    @(posedge clk); #1;
    rst_n = 1;
    set_exp(0, 0, 0, 0, 0);
    chk_en = 1;
    @(posedge clk); #1;

    // Model pins against hand-computed values.
    check("pin_sb_wdata", m_wrep(3'd0, 32'hAABB_CCDD), 32'hDDDD_DDDD);
    check("pin_sb_wstrb", m_strb(3'd0, 32'h3001), 4'b0010);
    check("pin_sh_wdata", m_wrep(3'd1, 32'hAABB_CCDD), 32'hCCDD_CCDD);
    check("pin_sh_wstrb", m_strb(3'd1, 32'h3002), 4'b1100);

    // LB with ack in the first REQ cycle.
    n_stall = 0; n_done = 0;
    access(0, 1, 3'd0, 32'h1003, 32'h0, 0, 32'h80FF_1234);
    check("lb_r_data", r_data, 32'hFFFF_FF80);
    check("lb_stall_cycles", n_stall, 2);
    check("lb_done_cycles", n_done, 1);

    access(0, 1, 3'd5, 32'h2002, 32'h0, 1, 32'hBEEF_0000);
    check("lhu_r_data", r_data, 32'h0000_BEEF);
    access(0, 1, 3'd1, 32'h2002, 32'h0, 0, 32'hBEEF_0000);
    check("lh_r_data", r_data, 32'hFFFF_BEEF);
    access(0, 1, 3'd2, 32'h2000, 32'h0, 2, 32'h1234_5678);
    check("lw_r_data", r_data, 32'h1234_5678);

    access(1, 0, 3'd0, 32'h3001, 32'hAABB_CCDD, 1, 32'h0);
    access(1, 0, 3'd1, 32'h3002, 32'hAABB_CCDD, 0, 32'h0);
    check("store_keeps_r_data", r_data, 32'h1234_5678);

    // Misaligned / illegal: one stall cycle, no bus activity.
    n_stall = 0; n_req = 0;
    access(0, 1, 3'd2, 32'h4002, 32'h0, 0, 32'h0);
    check("misaligned_lw_stall", n_stall, 1);
    access(0, 1, 3'd1, 32'h4001, 32'h0, 0, 32'h0);
    access(0, 1, 3'd3, 32'h4000, 32'h0, 0, 32'h0);
    check("err_no_bus_req", n_req, 0);
    check("err_keeps_r_data", r_data, 32'h1234_5678);

    // Timeout, then a stray late ack, then a normal load.
    n_req = 0;
    access(0, 1, 3'd2, 32'h5000, 32'h0, 99, 32'h0);
    check("tmo_req_cycles", n_req, TMO);
    check("tmo_r_data", r_data, 32'h0);
    bus_ack = 1; bus_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    bus_ack = 0;
    access(0, 1, 3'd2, 32'h6000, 32'h0, 2, 32'hCAFE_F00D);
    check("post_tmo_lw", r_data, 32'hCAFE_F00D);

    // Reset while a load sits in REQ.
    chk_en = 0;
    mem_read = 1; funct3 = 3'd2; addr = 32'h7000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_bus_req", bus_req, 1'b1);
    #2;
    rst_n = 0; mem_read = 0;
    #1;
    check("mid_rst_bus_req", bus_req, 1'b0);
    check("mid_rst_stall", stall, 1'b0);
    check("mid_rst_r_data", r_data, 32'h0);
    @(posedge clk); #1;
    rst_n = 1;
    m_rdata = 0;
    set_exp(0, 0, 0, 0, 0);
    bus_ack = 1;
    @(posedge clk); #1;
    bus_ack = 0;
    chk_en = 1;
    @(posedge clk); #1;

    // Randomized transactions.
    for (int i = 0; i < 80; i++) begin
      bit wr, rd;
      wr = 1'($urandom_range(0, 1));
      rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      access(wr, rd, 3'($urandom_range(0, 7)), $urandom, $urandom,
             $urandom_range(0, 5), $urandom);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
